// File: rtl/regfile_pkg.sv
// Shared types for the shadow register file: context operation encoding,
// copy-engine state and the bank-index width helper.
package regfile_pkg;

  typedef enum logic {
    CTX_SAVE    = 1'b0,
    CTX_RESTORE = 1'b1
  } ctx_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } ctx_state_e;

  // A single bank still needs one select bit so ports never collapse to zero width.
  function automatic int calc_bank_w(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 1;
  endfunction

endpackage

// File: rtl/shadow_regfile_if.sv
// CPU-side bus of the shadow register file: read/write ports, context request
// handshake, status pulses and the copy-engine state for observation.
interface shadow_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NBANKS = 3
);
  localparam int BANK_W = regfile_pkg::calc_bank_w(NBANKS);

  logic [ADDR_W-1:0] r1_num;
  logic [ADDR_W-1:0] r2_num;
  logic [DATA_W-1:0] r1_data;
  logic [DATA_W-1:0] r2_data;
  logic              we;
  logic [ADDR_W-1:0] w_num;
  logic [DATA_W-1:0] din;

  // Handshake: a request transfers on a rising edge where ctx_valid and ctx_ready
  // are both high; ctx_op/ctx_bank are sampled only on that edge. ctx_ready does
  // not depend on ctx_valid, and the master may drop or change an unaccepted request.
  logic              ctx_valid;
  logic              ctx_ready;
  logic              ctx_op;
  logic [BANK_W-1:0] ctx_bank;
  logic              busy;
  logic              ctx_done;
  logic              ctx_err;
  logic              wr_drop;
  regfile_pkg::ctx_state_e ctx_state;

  modport master (
    output r1_num, r2_num, we, w_num, din, ctx_valid, ctx_op, ctx_bank,
    input  r1_data, r2_data, ctx_ready, busy, ctx_done, ctx_err, wr_drop, ctx_state
  );

  modport slave (
    input  r1_num, r2_num, we, w_num, din, ctx_valid, ctx_op, ctx_bank,
    output r1_data, r2_data, ctx_ready, busy, ctx_done, ctx_err, wr_drop, ctx_state
  );

endinterface

// File: rtl/regfile_ctx_seq.sv
// Context save/restore sequencer: accepts a request, walks the register index
// (or fires once in fast mode) and produces the done/error/drop pulses.
module regfile_ctx_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int NBANKS    = 3,
  parameter int FAST_SWAP = 0,
  parameter int BANK_W    = calc_bank_w(NBANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctx_valid,
  input  logic              ctx_op,
  input  logic [BANK_W-1:0] ctx_bank,
  input  logic              we,
  output logic              ctx_ready,
  output logic              busy,
  output logic              ctx_done,
  output logic              ctx_err,
  output logic              wr_drop,
  output logic              copy_en,
  output logic [ADDR_W-1:0] copy_idx,
  output ctx_op_e           op_q,
  output logic [BANK_W-1:0] bank_q,
  output ctx_state_e        state
);

  localparam logic [BANK_W:0]   NB   = (BANK_W+1)'(NBANKS);
  localparam logic [ADDR_W-1:0] LAST = '1;

  logic [ADDR_W-1:0] cnt;
  logic              err_q;
  logic              drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= CTX_SAVE;
      bank_q <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= we && (state == COPY);
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (ctx_valid) begin
            op_q   <= ctx_op_e'(ctx_op);
            bank_q <= ctx_bank;
            // An out-of-range bank skips the copy and reports through ctx_err.
            if ({1'b0, ctx_bank} >= NB) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              state <= COPY;
            end
          end
        end
        COPY: begin
          if (FAST_SWAP != 0 || cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctx_ready = (state == IDLE);
  assign busy      = (state == COPY);
  assign ctx_done  = (state == DONE);
  assign ctx_err   = err_q;
  assign wr_drop   = drop_q;
  assign copy_en   = (state == COPY);
  assign copy_idx  = cnt;

endmodule

// File: rtl/shadow_regfile.sv
// Two-read/one-write register file with NBANKS shadow banks; the sequencer
// drives bulk save (live->bank) and restore (bank->live) copies.
module shadow_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NBANKS    = 3,
  parameter int FAST_SWAP = 0,
  parameter int ZERO_R0   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  shadow_regfile_if.slave  bus
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int BANK_W = calc_bank_w(NBANKS);

  logic [DATA_W-1:0] live [DEPTH];
  logic [DATA_W-1:0] bank [NBANKS][DEPTH];

  logic              busy;
  logic              copy_en;
  logic [ADDR_W-1:0] copy_idx;
  ctx_op_e           op_q;
  logic [BANK_W-1:0] bank_q;
  logic              wr_ok;

  regfile_ctx_seq #(
    .ADDR_W    (ADDR_W),
    .NBANKS    (NBANKS),
    .FAST_SWAP (FAST_SWAP),
    .BANK_W    (BANK_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctx_valid (bus.ctx_valid),
    .ctx_op    (bus.ctx_op),
    .ctx_bank  (bus.ctx_bank),
    .we        (bus.we),
    .ctx_ready (bus.ctx_ready),
    .busy      (busy),
    .ctx_done  (bus.ctx_done),
    .ctx_err   (bus.ctx_err),
    .wr_drop   (bus.wr_drop),
    .copy_en   (copy_en),
    .copy_idx  (copy_idx),
    .op_q      (op_q),
    .bank_q    (bank_q),
    .state     (bus.ctx_state)
  );

  assign bus.busy = busy;

  // Writes are refused while a copy owns the array; the sequencer flags the drop.
  assign wr_ok = bus.we && !busy && !(ZERO_R0 != 0 && bus.w_num == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        live[i] <= '0;
        for (int b = 0; b < NBANKS; b++) begin
          bank[b][i] <= '0;
        end
      end
    end else begin
      if (wr_ok) begin
        live[bus.w_num] <= bus.din;
      end
      if (copy_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (FAST_SWAP != 0 || ADDR_W'(i) == copy_idx) begin
            if (op_q == CTX_SAVE) begin
              bank[bank_q][i] <= live[i];
            end else if (!(ZERO_R0 != 0 && i == 0)) begin
              live[i] <= bank[bank_q][i];
            end
          end
        end
      end
    end
  end

  assign bus.r1_data = (ZERO_R0 != 0 && bus.r1_num == '0) ? '0 : live[bus.r1_num];
  assign bus.r2_data = (ZERO_R0 != 0 && bus.r2_num == '0) ? '0 : live[bus.r2_num];

endmodule

// File: tb/tb_shadow_regfile.sv
// Bench for shadow_regfile: a per-register copy instance and a fast-swap
// instance share one stimulus set, checked against array-level models.
module tb_shadow_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NBANKS = 3;
  localparam int DEPTH  = 32;
  localparam int BANK_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shadow_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NBANKS(NBANKS)) sif ();
  shadow_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NBANKS(NBANKS)) fif ();

  shadow_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NBANKS(NBANKS), .FAST_SWAP(0), .ZERO_R0(1))
    dut (.clk(clk), .rst_n(rst_n), .bus(sif));
  shadow_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NBANKS(NBANKS), .FAST_SWAP(1), .ZERO_R0(1))
    dut_fast (.clk(clk), .rst_n(rst_n), .bus(fif));

  // shared stimulus; sel_fast chooses which instance sees we/ctx_valid
  bit                sel_fast = 1'b0;
  logic [ADDR_W-1:0] s_r1 = '0, s_r2 = '0, s_wn = '0;
  logic              s_we = 1'b0, s_valid = 1'b0, s_op = 1'b0;
  logic [BANK_W-1:0] s_bank = '0;
  logic [DATA_W-1:0] s_din = '0;

  assign sif.r1_num = s_r1;      assign fif.r1_num = s_r1;
  assign sif.r2_num = s_r2;      assign fif.r2_num = s_r2;
  assign sif.w_num = s_wn;       assign fif.w_num = s_wn;
  assign sif.din = s_din;        assign fif.din = s_din;
  assign sif.ctx_op = s_op;      assign fif.ctx_op = s_op;
  assign sif.ctx_bank = s_bank;  assign fif.ctx_bank = s_bank;
  assign sif.we = s_we & ~sel_fast;
  assign fif.we = s_we & sel_fast;
  assign sif.ctx_valid = s_valid & ~sel_fast;
  assign fif.ctx_valid = s_valid & sel_fast;

  logic [DATA_W-1:0] o_r1, o_r2;
  logic o_ready, o_busy, o_done, o_err, o_drop;
  assign o_r1    = sel_fast ? fif.r1_data   : sif.r1_data;
  assign o_r2    = sel_fast ? fif.r2_data   : sif.r2_data;
  assign o_ready = sel_fast ? fif.ctx_ready : sif.ctx_ready;
  assign o_busy  = sel_fast ? fif.busy      : sif.busy;
  assign o_done  = sel_fast ? fif.ctx_done  : sif.ctx_done;
  assign o_err   = sel_fast ? fif.ctx_err   : sif.ctx_err;
  assign o_drop  = sel_fast ? fif.wr_drop   : sif.wr_drop;

  // reference model: [instance][reg] and [instance][bank][reg]
  logic [DATA_W-1:0] m_live [2][DEPTH];
  logic [DATA_W-1:0] m_bank [2][NBANKS][DEPTH];

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < DEPTH; i++) begin
        m_live[c][i] = '0;
        for (int b = 0; b < NBANKS; b++) m_bank[c][b][i] = '0;
      end
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    int c;
    c = sel_fast ? 1 : 0;
    s_we = 1'b1; s_wn = ADDR_W'(a); s_din = d;
    step();
    s_we = 1'b0;
    if (a != 0) m_live[c][a] = d;
  endtask

  task automatic check_all(input string tag);
    int c;
    int j;
    c = sel_fast ? 1 : 0;
    for (int i = 0; i < DEPTH; i++) begin
      j = DEPTH - 1 - i;
      s_r1 = ADDR_W'(i); s_r2 = ADDR_W'(j);
      #1;
      n_checks++;
      if (o_r1 !== m_live[c][i]) begin
        n_fail++;
        $display("FAIL %s r1 reg%0d: got %h expected %h", tag, i, o_r1, m_live[c][i]);
      end else n_pass++;
      n_checks++;
      if (o_r2 !== m_live[c][j]) begin
        n_fail++;
        $display("FAIL %s r2 reg%0d: got %h expected %h", tag, j, o_r2, m_live[c][j]);
      end else n_pass++;
    end
    step();
  endtask

  // Issue one context request and check its timing; drop_at>0 writes r3 in that COPY cycle.
  task automatic do_ctx(input logic op, input logic [BANK_W-1:0] b, input int drop_at, input string tag);
    int c, L, n, busy_n, drop_n, exp_lat, exp_busy, exp_drop;
    bit bad, err_v;
    c = sel_fast ? 1 : 0;
    L = sel_fast ? 1 : DEPTH;
    bad = (int'(b) >= NBANKS);
    exp_lat = bad ? 1 : L + 1;
    exp_busy = bad ? 0 : L;
    exp_drop = (drop_at > 0 && !bad) ? 1 : 0;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before_accept: got %b expected 1", tag, o_ready);
    end else n_pass++;
    s_valid = 1'b1; s_op = op; s_bank = b;
    step();
    n = 1; busy_n = 0; drop_n = 0; err_v = 1'b0;
    while (n <= L + 5) begin
      if (o_busy) busy_n++;
      if (o_drop) drop_n++;
      if (o_done) begin
        err_v = o_err;
        break;
      end
      // requests held during the copy must be ignored
      s_valid = 1'b1; s_op = 1'($urandom); s_bank = BANK_W'($urandom);
      s_we = (n == drop_at); s_wn = 5'd3; s_din = 32'h0000_00AA;
      step();
      n++;
    end
    s_valid = 1'b0; s_we = 1'b0;
    n_checks++;
    if (n !== exp_lat) begin
      n_fail++; $display("FAIL %s done_latency: got %0d expected %0d", tag, n, exp_lat);
    end else n_pass++;
    n_checks++;
    if (err_v !== bad) begin
      n_fail++; $display("FAIL %s ctx_err: got %b expected %b", tag, err_v, bad);
    end else n_pass++;
    n_checks++;
    if (busy_n !== exp_busy) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_n, exp_busy);
    end else n_pass++;
    step();
    if (o_drop) drop_n++;
    n_checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_after_done: got ready=%b done=%b expected 1/0", tag, o_ready, o_done);
    end else n_pass++;
    n_checks++;
    if (drop_n !== exp_drop) begin
      n_fail++; $display("FAIL %s wr_drop_pulses: got %0d expected %0d", tag, drop_n, exp_drop);
    end else n_pass++;
    if (!bad) begin
      if (op == 1'b0) begin
        for (int i = 0; i < DEPTH; i++) m_bank[c][b][i] = m_live[c][i];
      end else begin
        for (int i = 1; i < DEPTH; i++) m_live[c][i] = m_bank[c][b][i];
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_we = 1'b0; s_valid = 1'b0;
    repeat (3) step();
    for (int f = 0; f < 2; f++) begin
      sel_fast = f[0];
      #1;
      n_checks++;
      if ({o_ready, o_busy, o_done, o_err, o_drop} !== 5'b10000) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d: got %b expected 10000", f, {o_ready, o_busy, o_done, o_err, o_drop});
      end else n_pass++;
    end
    rst_n = 1'b1;
    step();
    model_reset();
    sel_fast = 1'b0; check_all("reset_slow");
    sel_fast = 1'b1; check_all("reset_fast");
    sel_fast = 1'b0;
  endtask

  task automatic test_read_write();
    sel_fast = 1'b0;
    wr(5, 32'hDEAD_BEEF);
    s_r1 = 5'd5; #1;
    n_checks++;
    if (o_r1 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rw_r5: got %h expected deadbeef", o_r1);
    end else n_pass++;
    // same-cycle read must still see the old value
    s_we = 1'b1; s_wn = 5'd6; s_din = 32'h1234_5678; s_r2 = 5'd6; #1;
    n_checks++;
    if (o_r2 !== m_live[0][6]) begin
      n_fail++; $display("FAIL rw_no_bypass: got %h expected %h", o_r2, m_live[0][6]);
    end else n_pass++;
    step();
    s_we = 1'b0;
    m_live[0][6] = 32'h1234_5678;
    wr(0, 32'h1);
    s_r1 = 5'd0; #1;
    n_checks++;
    if (o_r1 !== 32'h0) begin
      n_fail++; $display("FAIL rw_r0_zero: got %h expected 0", o_r1);
    end else n_pass++;
    for (int k = 0; k < 40; k++) wr($urandom_range(0, DEPTH - 1), $urandom);
    check_all("rw_random");
  endtask

  task automatic test_save_restore(input bit fast);
    int c;
    sel_fast = fast;
    c = fast ? 1 : 0;
    for (int i = 1; i < DEPTH; i++) wr(i, DATA_W'(i));
    do_ctx(1'b0, 2'd1, 0, fast ? "fast_save" : "slow_save");
    for (int i = 0; i < DEPTH; i++) wr(i, 32'hFFFF_FFFF);
    check_all(fast ? "fast_overwritten" : "slow_overwritten");
    do_ctx(1'b1, 2'd1, 0, fast ? "fast_restore" : "slow_restore");
    s_r1 = 5'd7; #1;
    n_checks++;
    if (o_r1 !== 32'd7) begin
      n_fail++; $display("FAIL restore_r7 inst%0d: got %h expected 7", c, o_r1);
    end else n_pass++;
    check_all(fast ? "fast_restored" : "slow_restored");
  endtask

  task automatic test_wr_drop();
    sel_fast = 1'b0;
    wr(3, 32'h5555_0003);
    do_ctx(1'b0, 2'd0, 5, "slow_drop");
    check_all("slow_drop_regs");
    sel_fast = 1'b1;
    do_ctx(1'b1, 2'd2, 1, "fast_drop");
    check_all("fast_drop_regs");
    sel_fast = 1'b0;
  endtask

  task automatic test_accept_write();
    logic [DATA_W-1:0] d;
    sel_fast = 1'b0;
    d = $urandom;
    s_we = 1'b1; s_wn = 5'd9; s_din = d;
    m_live[0][9] = d;
    do_ctx(1'b0, 2'd2, 0, "accept_wr_save");
    wr(9, ~d);
    do_ctx(1'b1, 2'd2, 0, "accept_wr_restore");
    s_r1 = 5'd9; #1;
    n_checks++;
    if (o_r1 !== d) begin
      n_fail++; $display("FAIL accept_write_r9: got %h expected %h", o_r1, d);
    end else n_pass++;
    check_all("accept_write_regs");
  endtask

  task automatic test_bad_bank();
    for (int f = 0; f < 2; f++) begin
      sel_fast = f[0];
      do_ctx(1'($urandom), 2'd3, 0, f ? "fast_bad_bank" : "slow_bad_bank");
      check_all(f ? "fast_bad_regs" : "slow_bad_regs");
    end
    sel_fast = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      sel_fast = f[0];
      do_ctx(1'b0, 2'd0, 0, "b2b_first");
      do_ctx(1'b1, 2'd2, 0, "b2b_second");
      do_ctx(1'b1, 2'd0, 0, "b2b_third");
      check_all("b2b_regs");
    end
    sel_fast = 1'b0;
  endtask

  task automatic test_random();
    int dz;
    for (int k = 0; k < 10; k++) begin
      sel_fast = 1'($urandom);
      for (int w = 0; w < 4; w++) wr($urandom_range(0, DEPTH - 1), $urandom);
      dz = ($urandom_range(0, 2) == 0) ? $urandom_range(1, sel_fast ? 1 : DEPTH) : 0;
      do_ctx(1'($urandom), 2'($urandom_range(0, 3)), dz, "rand_ctx");
    end
    sel_fast = 1'b0; check_all("rand_slow");
    sel_fast = 1'b1; check_all("rand_fast");
    sel_fast = 1'b0;
  endtask

  task automatic test_reset_mid_restore();
    int done_n;
    sel_fast = 1'b0;
    do_ctx(1'b0, 2'd1, 0, "mid_prep_save");
    s_valid = 1'b1; s_op = 1'b1; s_bank = 2'd1;
    step();
    s_valid = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_ready, o_busy, o_done} !== 3'b100) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %b expected 100", {o_ready, o_busy, o_done});
    end else n_pass++;
    model_reset();
    check_all("mid_reset_regs");
    rst_n = 1'b1;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_done) done_n++;
    end
    n_checks++;
    if (done_n !== 0) begin
      n_fail++; $display("FAIL mid_reset_no_done: got %0d pulses expected 0", done_n);
    end else n_pass++;
    do_ctx(1'b1, 2'd1, 0, "mid_reset_restore_cleared");
    check_all("mid_reset_bank_cleared");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_read_write();
    test_save_restore(1'b0);
    test_save_restore(1'b1);
    test_wr_drop();
    test_accept_write();
    test_bad_bank();
    test_back_to_back();
    test_random();
    test_reset_mid_restore();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
